mmio_button_fifo: RTL and testbench
===================================

// Module: mmio_button_fifo
// PURPOSE
//  Memory-mapped responder on the processor data-memory bus (wren/address_dmem/data/q_dmem).
//  Debounces the board push-buttons and queues press/release events in a FIFO.
//  Game software polls the queue with lw and consumes events with sw.
//  The wrapper decodes q_mmio vs RAM dataOut using mmio_sel.
// PARAMETERS
//  BASE_ADDR        12'hF00   word address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3
//  DEPTH            8         FIFO entries, power of two, >=2
//  NUM_BTNS         4         buttons; event index is 2 bits
//  DEBOUNCE_CYCLES  1000000   consecutive stable cycles needed to accept a level change (<2^20)
// PORTS
//  clock         in   1   system clock, all logic on posedge
//  CPU_RESETN    in   1   synchronous active-low reset
//  btn           in   NUM_BTNS  raw asynchronous buttons, active-high
//  wren          in   1   processor store strobe
//  address_dmem  in   12  word address from processor
//  data          in   32  store data from processor
//  q_mmio        out  32  registered read data
//  mmio_sel      out  1   registered; 1 = q_mmio is valid for the previous cycle's address
//  irq_pending   out  1   combinational ~empty
// BEHAVIOUR
//  Reset (CPU_RESETN=0 at posedge): FIFO empty, count=0, overflow=0, all pending=0,
//   debounced levels=0, sync flops=0, q_mmio=0, mmio_sel=0.
//  Input path per button: 2-flop synchroniser -> debouncer.
//   A 20-bit counter runs while sync2 != stable and clears when they are equal.
//   When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, stable<=sync2 and counter<=0.
//   On the same edge set pend_press[i] (0->1) or pend_rel[i] (1->0).
//  Latency: a clean btn edge is enqueued exactly DEBOUNCE_CYCLES+3 posedges later, if FIFO not full.
//  A button held through reset produces a press event after reset.
//  Arbiter: one enqueue per cycle. The lowest button index wins; press beats release for the same index.
//   The winning pending bit clears on enqueue. Others wait, with no loss.
//  Entry format is 3 bits: [2]=1 press/0 release, [1:0]=button index.
//  Register map (word offsets from BASE_ADDR):
//   +0 EVENT  RO  {valid, 28'b0, head_entry}; valid=~empty; reads 0 when empty. Does not pop.
//   +1 STATUS RO  {22'b0, overflow, full, empty, 3'b0, count[3:0]}
//   +2 POP    WO  any write with wren=1 pops the head if non-empty; ignored if empty
//   +3 CTRL   WO  data[0]=1 flush (count<=0, pending<=0); data[1]=1 clear overflow
//  Reads: q_mmio and mmio_sel register the decode of address_dmem every cycle, giving 1-cycle latency (same as RAM).
//   Writes to RO offsets are ignored. Addresses outside the window give mmio_sel=0 and q_mmio=0.
//  Full: the enqueue is refused, the winning pending bit is cleared (event dropped), and overflow<=1 (sticky).
//  Pop and enqueue on the same edge: both happen and count is unchanged. This holds when full, so nothing is dropped.
//  Flush and enqueue on the same edge: flush wins, the event and all pending bits are discarded.
//   Debounced levels are kept, so no spurious events follow.
//  Flush and clear-overflow may be combined in one write.
//  Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
//  Reset asserted mid-debounce or mid-transfer: everything returns to reset values on that edge.
// TESTING  (DEBOUNCE_CYCLES=4, DEPTH=4, BASE_ADDR=12'hF00)
//  Case 1: btn[1] 0->1 held.
//   STATUS count goes 0->1 exactly 7 posedges later.
//   lw F00 gives q_mmio=32'h8000_0005 one cycle later; sw F02 then gives count=0 and EVENT=0.
//  Case 2: btn[0] glitches high for 3 cycles, then low.
//   No event is queued and count stays 0.
//  Case 3: btn[3:0] 0000->1111 in one cycle.
//   Four entries enqueue on consecutive cycles in order 4,5,6,7; full=1.
//  Case 4: with FIFO full, release all buttons.
//   overflow=1, count=4, head still 4.
//   A single sw F02 coinciding with an enqueue gives count=4, head 5.
//  Case 5: sw F03 data=3 while events are pending.
//   count=0, overflow=0, and no further events until the next real edge.
//  Case 6: CPU_RESETN=0 for 1 cycle mid-debounce with count=2.
//   All outputs return to 0 and count=0; a held button re-reports its press after reset.

Source files
------------

// File: rtl/mmio_button_fifo.sv
// -----------------------------------------------------------------------------
// mmio_button_fifo
//   Memory-mapped push-button event queue on the processor data-memory bus.
//   Each raw button is synchronised (2 flops) and debounced. Every accepted
//   level change becomes a press/release event. Events are queued in a small
//   FIFO that software polls (EVENT/STATUS) and consumes (POP/CTRL).
//
//   Entry format (3 bits): [2] = 1 press / 0 release, [1:0] = button index.
//
//   Register map (word offsets from BASE_ADDR):
//     +0 EVENT   RO  {valid, 28'b0, head_entry}; reads 0 when empty
//     +1 STATUS  RO  {22'b0, overflow, full, empty, 3'b0, count[3:0]}
//     +2 POP     WO  any write pops the head if non-empty
//     +3 CTRL    WO  data[0] flush, data[1] clear overflow
//
// Ports
//   clock         in   system clock, posedge
//   CPU_RESETN    in   synchronous active-low reset
//   btn           in   raw asynchronous buttons, active-high
//   wren          in   processor store strobe
//   address_dmem  in   12-bit word address
//   data          in   32-bit store data
//   q_mmio        out  registered read data (1-cycle latency, like RAM)
//   mmio_sel      out  registered; 1 when the previous address hit the window
//   irq_pending   out  combinational, FIFO not empty
// -----------------------------------------------------------------------------
module mmio_button_fifo #(
  parameter logic [11:0] BASE_ADDR       = 12'hF00,
  parameter int          DEPTH           = 8,
  parameter int          NUM_BTNS        = 4,
  parameter int          DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                CPU_RESETN,
  input  logic [NUM_BTNS-1:0] btn,
  input  logic                wren,
  input  logic [11:0]         address_dmem,
  input  logic [31:0]         data,
  output logic [31:0]         q_mmio,
  output logic                mmio_sel,
  output logic                irq_pending
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  // Input path state
  logic [NUM_BTNS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
  logic [19:0]         cnt_q [NUM_BTNS];
  logic [19:0]         cnt_d [NUM_BTNS];
  logic [NUM_BTNS-1:0] rise, fall;

  // Event state
  logic [NUM_BTNS-1:0] pend_press_q, pend_press_d, pend_rel_q, pend_rel_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [2:0]          mem_q [DEPTH];

  // Bus-side state
  logic [31:0]         q_mmio_q, q_mmio_d;
  logic                mmio_sel_q, mmio_sel_d;

  // Decode and arbitration
  logic [12:0]         off;
  logic                in_win, bus_wr, pop, flush, clr_ov;
  logic                empty, full;
  logic [2:0]          head;
  logic                win_valid, push, drop;
  logic [2:0]          win_entry;
  logic [NUM_BTNS-1:0] win_press, win_rel;

  // Only data[1:0] carry meaning for CTRL writes.
  logic unused_data;
  assign unused_data = ^data[31:2];

  // ---------------------------------------------------------------------------
  // Synchroniser + debouncer
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sync1_d  = btn;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    rise     = '0;
    fall     = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          rise[i]     = sync2_q[i];
          fall[i]     = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode, arbiter and FIFO control
  // ---------------------------------------------------------------------------
  // 13-bit subtraction: addresses below BASE_ADDR wrap to large values and
  // therefore fall outside the window.
  assign off    = {1'b0, address_dmem} - {1'b0, BASE_ADDR};
  assign in_win = (off < 13'd4);
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign head   = mem_q[rd_ptr_q];
  assign bus_wr = wren && in_win;
  assign pop    = bus_wr && (off[1:0] == 2'd2) && !empty;
  assign flush  = bus_wr && (off[1:0] == 2'd3) && data[0];
  assign clr_ov = bus_wr && (off[1:0] == 2'd3) && data[1];

  always_comb begin
    win_valid = 1'b0;
    win_entry = '0;
    win_press = '0;
    win_rel   = '0;
    // Lowest index first; press beats release for the same button.
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (!win_valid) begin
        if (pend_press_q[i]) begin
          win_valid    = 1'b1;
          win_entry    = {1'b1, 2'(i)};
          win_press[i] = 1'b1;
        end else if (pend_rel_q[i]) begin
          win_valid  = 1'b1;
          win_entry  = {1'b0, 2'(i)};
          win_rel[i] = 1'b1;
        end
      end
    end
  end

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push = win_valid && !flush && (!full || pop);
  assign drop = win_valid && !flush && full && !pop;

  always_comb begin
    pend_press_d = flush ? '0 : ((pend_press_q & ~win_press) | rise);
    pend_rel_d   = flush ? '0 : ((pend_rel_q & ~win_rel) | fall);
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
    // A drop on the same edge as a clear leaves overflow set: an event was lost.
    overflow_d = (overflow_q && !clr_ov) || drop;
  end

  // ---------------------------------------------------------------------------
  // Read data, registered every cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    mmio_sel_d = in_win;
    q_mmio_d   = '0;
    if (in_win) begin
      case (off[1:0])
        2'd0:    q_mmio_d = empty ? 32'd0 : {1'b1, 28'd0, head};
        2'd1:    q_mmio_d = {22'd0, overflow_q, full, empty, 3'd0, 4'(count_q)};
        default: q_mmio_d = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!CPU_RESETN) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      for (int i = 0; i < NUM_BTNS; i++) cnt_q[i] <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      q_mmio_q     <= '0;
      mmio_sel_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      for (int i = 0; i < NUM_BTNS; i++) cnt_q[i] <= cnt_d[i];
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      q_mmio_q     <= q_mmio_d;
      mmio_sel_q   <= mmio_sel_d;
    end
  end

  // NOTE: the entry storage has no reset; count gates every read of it, so
  // stale contents are never observable and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= win_entry;
  end

  assign q_mmio      = q_mmio_q;
  assign mmio_sel    = mmio_sel_q;
  assign irq_pending = !empty;

endmodule

// File: tb/tb_mmio_button_fifo.sv
// -----------------------------------------------------------------------------
// tb_mmio_button_fifo
//   Directed bench for mmio_button_fifo (DEBOUNCE_CYCLES=4, DEPTH=4).
//   A queue-based model tracks the event stream at the level of "delayed
//   button sample held for N edges -> event", and the outputs are compared
//   against it at every negedge. Literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_mmio_button_fifo;

  localparam int          D    = 4;
  localparam int          DEP  = 4;
  localparam int          NB   = 4;
  localparam logic [11:0] BASE = 12'hF00;

  logic          clock = 1'b0;
  logic          CPU_RESETN;
  logic [NB-1:0] btn;
  logic          wren;
  logic [11:0]   address_dmem;
  logic [31:0]   data;
  logic [31:0]   q_mmio;
  logic          mmio_sel;
  logic          irq_pending;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mmio_button_fifo #(
    .BASE_ADDR       (BASE),
    .DEPTH           (DEP),
    .NUM_BTNS        (NB),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock        (clock),
    .CPU_RESETN   (CPU_RESETN),
    .btn          (btn),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .q_mmio       (q_mmio),
    .mmio_sel     (mmio_sel),
    .irq_pending  (irq_pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [NB-1:0] in_hist [$];   // [0] = this edge's sample, [2] = two edges ago
  int            run [NB];      // consecutive edges the delayed input disagreed
  logic [NB-1:0] lvl, m_press, m_rel;
  logic [2:0]    m_fifo [$];
  logic          m_ov;
  logic [31:0]   exp_q;
  logic          exp_sel, exp_irq;

  always @(posedge clock) begin : model
    int            off;
    bit            in_win, pop, flush, clr, found;
    logic [2:0]    ent;
    logic [NB-1:0] dly, nr, nf;
    if (!CPU_RESETN) begin
      in_hist = '{'0, '0, '0};
      for (int i = 0; i < NB; i++) run[i] = 0;
      lvl = '0; m_press = '0; m_rel = '0; m_ov = 1'b0;
      m_fifo.delete();
      exp_q = '0; exp_sel = 1'b0;
    end else begin
      off    = int'(address_dmem) - int'(BASE);
      in_win = (off >= 0) && (off < 4);
      exp_sel = in_win;
      exp_q   = '0;
      if (in_win && off == 0 && m_fifo.size() > 0) exp_q = {1'b1, 28'd0, m_fifo[0]};
      if (in_win && off == 1)
        exp_q = {22'd0, m_ov, m_fifo.size() == DEP, m_fifo.size() == 0, 3'd0, 4'(m_fifo.size())};
      pop   = wren && in_win && off == 2 && m_fifo.size() > 0;
      flush = wren && in_win && off == 3 && data[0];
      clr   = wren && in_win && off == 3 && data[1];
      found = 1'b0; ent = '0;
      for (int i = 0; i < NB; i++) begin
        if (!found && m_press[i]) begin found = 1'b1; ent = {1'b1, 2'(i)}; m_press[i] = 1'b0; end
        else if (!found && m_rel[i]) begin found = 1'b1; ent = {1'b0, 2'(i)}; m_rel[i] = 1'b0; end
      end
      in_hist.push_front(btn);
      void'(in_hist.pop_back());
      dly = in_hist[2];
      nr = '0; nf = '0;
      for (int i = 0; i < NB; i++) begin
        if (dly[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == D) begin
            lvl[i] = dly[i]; run[i] = 0;
            if (dly[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      if (flush) begin
        m_fifo.delete(); m_press = '0; m_rel = '0;
        if (clr) m_ov = 1'b0;
      end else begin
        if (clr) m_ov = 1'b0;
        if (pop) void'(m_fifo.pop_front());
        if (found) begin
          if (m_fifo.size() < DEP) m_fifo.push_back(ent);
          else m_ov = 1'b1;
        end
        m_press |= nr; m_rel |= nf;
      end
    end
    exp_irq = (m_fifo.size() != 0);
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("q_mmio", q_mmio, exp_q);
      check("mmio_sel", 32'(mmio_sel), 32'(exp_sel));
      check("irq_pending", 32'(irq_pending), 32'(exp_irq));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    address_dmem = a; wren = 1'b0;
    cyc(1);
    check(name, q_mmio, exp);
    address_dmem = BASE + 12'd1;
  endtask

  task automatic sw(input logic [11:0] a, input logic [31:0] d);
    address_dmem = a; data = d; wren = 1'b1;
    cyc(1);
    wren = 1'b0; data = '0; address_dmem = BASE + 12'd1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    CPU_RESETN = 1'b0; btn = '0; wren = 1'b0; address_dmem = '0; data = '0;
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    check("reset q_mmio", q_mmio, 32'd0);
    check("reset irq", 32'(irq_pending), 32'd0);
    CPU_RESETN = 1'b1;
    address_dmem = BASE + 12'd1;
    cyc(2);
    check("idle status", q_mmio, 32'h0000_0080);

    // Case 1: btn[1] press, 7-edge latency, read head, pop
    btn = 4'b0010;
    cyc(6);
    check("c1 irq before 7", 32'(irq_pending), 32'd0);
    cyc(1);
    check("c1 irq at 7", 32'(irq_pending), 32'd1);
    rd(BASE, 32'h8000_0005, "c1 event");
    sw(BASE + 12'd2, 32'd0);
    rd(BASE + 12'd1, 32'h0000_0080, "c1 status after pop");
    rd(BASE, 32'h0000_0000, "c1 event empty");
    btn = 4'b0000;
    cyc(10);
    rd(BASE, 32'h8000_0001, "c1 release event");
    sw(BASE + 12'd2, 32'd0);

    // Case 2: 3-cycle glitch on btn[0]
    btn = 4'b0001;
    cyc(3);
    btn = 4'b0000;
    cyc(12);
    check("c2 irq", 32'(irq_pending), 32'd0);
    rd(BASE + 12'd1, 32'h0000_0080, "c2 status");

    // Case 3: all buttons pressed together
    btn = 4'b1111;
    cyc(6);
    check("c3 irq before 7", 32'(irq_pending), 32'd0);
    cyc(4);
    rd(BASE + 12'd1, 32'h0000_0104, "c3 status full");
    rd(BASE, 32'h8000_0004, "c3 head");
    rd(BASE + 12'd5, 32'h0000_0000, "out of window");
    check("out of window sel", 32'(mmio_sel), 32'd0);

    // Case 4: release all while full; one pop coincides with rel1 enqueue
    btn = 4'b0000;
    cyc(7);
    sw(BASE + 12'd2, 32'd0);
    cyc(4);
    rd(BASE + 12'd1, 32'h0000_0304, "c4 status overflow");
    rd(BASE, 32'h8000_0005, "c4 head");

    // Case 5: flush + clear overflow while btn[2] press is pending
    btn = 4'b0100;
    cyc(6);
    sw(BASE + 12'd3, 32'd3);
    cyc(10);
    check("c5 irq", 32'(irq_pending), 32'd0);
    rd(BASE + 12'd1, 32'h0000_0080, "c5 status");

    // Build count=2: release btn2 (entry 2), press btn1 (entry 5)
    btn = 4'b0000;
    cyc(10);
    btn = 4'b0010;
    cyc(10);
    rd(BASE + 12'd1, 32'h0000_0002, "c6 pre status");
    rd(BASE, 32'h8000_0002, "c6 pre head");

    // Case 6: reset mid-debounce of btn[0], btn[1] still held
    btn = 4'b0011;
    cyc(3);
    CPU_RESETN = 1'b0;
    cyc(1);
    CPU_RESETN = 1'b1;
    check("c6 reset q_mmio", q_mmio, 32'd0);
    check("c6 reset sel", 32'(mmio_sel), 32'd0);
    check("c6 reset irq", 32'(irq_pending), 32'd0);
    cyc(10);
    rd(BASE + 12'd1, 32'h0000_0002, "c6 status after reset");
    rd(BASE, 32'h8000_0004, "c6 head after reset");
    cyc(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
